// File: rtl/ao4_status_capture.sv
// ao4_status_capture
// Samples the Ao4 gate-stage status vector {y,q,r} every clock and records
// each change together with a free-running timestamp. Records are buffered in
// a small FIFO and drained by a trace reader over a valid/ready handshake.
// Changes arriving while the FIFO is full (and no pop is happening) are
// dropped, and a sticky overflow flag is raised.
//
// Build option:
//   ST_CAP_OVF_CNT_EN - adds the ovf_count port and a saturating 8-bit
//                       count of dropped records.
module ao4_status_capture #(
  parameter  int DEPTH = 8,
  parameter  int TS_W  = 12,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              y_in,
  input  logic              q_in,
  input  logic              r_in,
  input  logic              rd_ready,
  input  logic              clr_ovf,
  output logic              rd_valid,
  output logic [TS_W+2:0]   rd_data,
  output logic [AW:0]       level,
  output logic              overflow
`ifdef ST_CAP_OVF_CNT_EN
  ,
  output logic [7:0]        ovf_count
`endif
);

  localparam int LW = AW + 1;

  // One trace record: timestamp in the upper bits, {y,q,r} in the low 3 bits.
  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [2:0]      status;
  } rec_t;

  logic [2:0]      s1_q, s1_d;
  logic [2:0]      prev_q, prev_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;

  logic            change;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            drop;
  rec_t            wr_rec;
  rec_t            mem_q [DEPTH];

  // Two-stage status pipeline and free-running timestamp.
  always_comb begin
    s1_d   = {y_in, q_in, r_in};
    prev_d = s1_q;
    ts_d   = ts_q + TS_W'(1);
  end

  // Change detection and FIFO accept / drop decisions.
  always_comb begin
    empty         = (level_q == '0);
    full          = (level_q == LW'(DEPTH));
    change        = en & (s1_q != prev_q);
    pop           = ~empty & rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push          = change & (~full | pop);
    drop          = change & full & ~pop;
    // The record carries the timestamp of the cycle in which change is seen.
    wr_rec.ts     = ts_q;
    wr_rec.status = s1_q;
  end

  // Pointer and occupancy next-state; level is its own counter, not derived
  // from the pointers, so full and empty are unambiguous.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Sticky overflow; a drop in the same cycle as clr_ovf wins.
  always_comb begin
    overflow_d = overflow_q;
    if (clr_ovf) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  // Control and pipeline state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      prev_q     <= '0;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values; prev_q gets the old s1_q, not the new one.
      s1_q       <= s1_d;
      prev_q     <= prev_d;
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Record storage, written at the tail on every accepted push.
  // NOTE: the storage array is deliberately not reset; level_q gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_rec;
  end

`ifdef ST_CAP_OVF_CNT_EN
  logic [7:0] ovf_count_q, ovf_count_d;
  logic [7:0] ovf_base;

  // Saturating drop counter; clr_ovf restarts it, a same-cycle drop counts as 1.
  always_comb begin
    ovf_base    = clr_ovf ? 8'd0 : ovf_count_q;
    ovf_count_d = ovf_base;
    if (drop && (ovf_base != 8'hFF)) ovf_count_d = ovf_base + 8'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_count_q <= '0;
    else        ovf_count_q <= ovf_count_d;
  end

  assign ovf_count = ovf_count_q;
`else
  // Overflow flag only in this build; no drop counter.
`endif

  // Head record is presented only while the FIFO holds data; zero otherwise.
  assign rd_valid = ~empty;
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ao4_status_capture.sv
// Directed bench for ao4_status_capture (DEPTH=8, TS_W=4). A cycle model
// pushes expected records into a scoreboard queue as stimulus is applied and
// pops them on each reader handshake; DUT outputs are compared on negedge.
module tb_ao4_status_capture;

  localparam int DEPTH = 8;
  localparam int TS_W  = 4;
  localparam int AW    = 3;
  localparam int RW    = TS_W + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          y_in, q_in, r_in;
  logic          rd_ready;
  logic          clr_ovf;
  logic          rd_valid;
  logic [RW-1:0] rd_data;
  logic [AW:0]   level;
  logic          overflow;
  logic [7:0]    ovf_count;

  ao4_status_capture #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .y_in     (y_in),
    .q_in     (q_in),
    .r_in     (r_in),
    .rd_ready (rd_ready),
    .clr_ovf  (clr_ovf),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .level    (level),
    .overflow (overflow)
`ifdef ST_CAP_OVF_CNT_EN
    ,
    .ovf_count(ovf_count)
`endif
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;

  // Model state and scoreboard.
  logic [RW-1:0] sb_q[$];
  logic [2:0]    m_s1, m_prev;
  logic [TS_W-1:0] m_ts;
  logic          m_ovf;
  int            m_cnt;
  logic [2:0]    cur;
  logic [2:0]    last_val;
  logic [2:0]    first_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_s1   = '0;
    m_prev = '0;
    m_ts   = '0;
    m_ovf  = 1'b0;
    m_cnt  = 0;
  endtask

  // One clock edge of the reference behaviour, using the pre-edge inputs.
  task automatic model_edge();
    logic chg, pop, full, drop;
    chg  = en && (m_s1 != m_prev);
    pop  = rd_ready && (sb_q.size() != 0);
    full = (sb_q.size() == DEPTH);
    drop = chg && full && !pop;
    if (pop) void'(sb_q.pop_front());
    if (chg && !drop) sb_q.push_back({m_ts, m_s1});
    if (clr_ovf) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
    if (drop) begin
      m_ovf = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
    m_prev = m_s1;
    m_s1   = {y_in, q_in, r_in};
    m_ts   = m_ts + 1'b1;
  endtask

  task automatic compare();
    check("rd_valid", rd_valid, sb_q.size() != 0);
    check("level", level, sb_q.size());
    check("overflow", overflow, m_ovf);
    if (sb_q.size() != 0) check("rd_data", rd_data, sb_q[0]);
`ifdef ST_CAP_OVF_CNT_EN
    check("ovf_count", ovf_count, m_cnt);
`endif
  endtask

  // Advance one clock: model follows the edge, DUT is sampled on negedge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input logic [2:0] v);
    {y_in, q_in, r_in} = v;
    cur = v;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      drive(cur + 3'd1);
      step();
    end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    rd_ready = 1'b0;
    clr_ovf  = 1'b0;
    drive(3'b000);
    model_reset();
    #1;
    check("reset_rd_valid", rd_valid, 0);
    check("reset_level", level, 0);
    check("reset_overflow", overflow, 0);
    check("reset_rd_data", rd_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single change 000 -> 101: visible one edge after s1 captures it.
    drive(3'b101);
    step();
    check("single_not_yet", rd_valid, 0);
    step();
    check("single_valid", rd_valid, 1);
    check("single_value", rd_data[2:0], 3'b101);
    check("single_level", level, 1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;

    // Fill with 9 changes: 8 stored, 9th dropped.
    first_val = cur + 3'd1;
    fill(9);
    check("fill_level", level, 8);
    check("fill_overflow", overflow, 1);
    check("fill_head", rd_data[2:0], first_val);
    rd_ready = 1'b1;
    repeat (8) step();
    rd_ready = 1'b0;
    check("fill_ninth_absent", rd_valid, 0);

    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("clr_overflow", overflow, 0);

    // Full FIFO with a same-cycle pop: push accepted, nothing dropped.
    fill(8);
    drive(cur + 3'd1);
    last_val = cur;
    step();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("fullpop_level", level, 8);
    check("fullpop_overflow", overflow, 0);
    rd_ready = 1'b1;
    repeat (7) step();
    check("fullpop_last", rd_data[2:0], last_val);
    step();
    rd_ready = 1'b0;

    // Timestamp wrap: records stamped 14 and then 1.
    for (int i = 0; i < 40 && m_ts != 4'd13; i++) step();
    drive(cur + 3'd1);
    step();
    for (int i = 0; i < 40 && m_ts != 4'd0; i++) step();
    drive(cur + 3'd1);
    step();
    step();
    check("wrap_level", level, 2);
    check("wrap_ts_first", rd_data[RW-1:3], 14);
    rd_ready = 1'b1;
    step();
    check("wrap_ts_second", rd_data[RW-1:3], 1);
    step();
    rd_ready = 1'b0;

    // Enable low: toggles are tracked but not recorded.
    drive(cur + 3'd1);
    step();
    step();
    en = 1'b0;
    repeat (3) begin
      drive(cur + 3'd1);
      step();
    end
    repeat (2) step();
    en = 1'b1;
    repeat (2) step();
    check("en_level", level, 1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;

    // clr_ovf in the same cycle as a drop: drop wins.
    fill(8);
    drive(cur + 3'd1);
    step();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("clrdrop_overflow", overflow, 1);
    check("clrdrop_level", level, 8);
`ifdef ST_CAP_OVF_CNT_EN
    check("clrdrop_count", ovf_count, 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("cnt_cleared", ovf_count, 0);
    repeat (300) begin
      drive(cur + 3'd1);
      step();
    end
    step();
    check("cnt_saturate", ovf_count, 255);
`endif
    rd_ready = 1'b1;
    repeat (8) step();
    rd_ready = 1'b0;

    // Asynchronous reset mid-stream with level 5 and overflow set.
    fill(5);
    check("prerst_level", level, 5);
    check("prerst_overflow", overflow, 1);
    #2;
    rst_n = 1'b0;
    drive(3'b000);
    model_reset();
    #1;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    drive(3'b011);
    step();
    step();
    check("rst_first_valid", rd_valid, 1);
    check("rst_first_ts", rd_data[RW-1:3], 2);
    check("rst_first_value", rd_data[2:0], 3'b011);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
